// File: rtl/multirate_pkg.sv
// Shared rate encodings, prescaler terminal-count helper and the
// active-low 7-segment pattern table for the multirate hex counter.
package multirate_pkg;

  typedef enum logic [1:0] {
    RATE_FAST = 2'd0,
    RATE_1X   = 2'd1,
    RATE_2X   = 2'd2,
    RATE_4X   = 2'd3
  } rate_e;

  // Bit order g..a (bit 0 = segment a), a lit segment is 0.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [31:0] rate_terminal(input rate_e rate, input logic [31:0] period);
    case (rate)
      RATE_FAST: rate_terminal = 32'd0;
      RATE_1X:   rate_terminal = period - 32'd1;
      RATE_2X:   rate_terminal = (period << 1) - 32'd1;
      default:   rate_terminal = (period << 2) - 32'd1;
    endcase
  endfunction

endpackage

// File: rtl/multirate_hex_counter_seg7.sv
// Single hex digit to active-low 7-segment decoder.
module hex_to_seg7
  import multirate_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/multirate_hex_counter.sv
// Selectable-rate prescaler driving a modulus up/down counter whose nibbles
// are decoded onto active-low 7-segment displays.
module multirate_hex_counter
  import multirate_pkg::*;
#(
  parameter int     N_DIGITS      = 4,
  parameter int     PERIOD_CYCLES = 50000000,
  parameter longint MODULUS       = longint'(1) << (4 * N_DIGITS)
) (
  input  logic                    CLOCK_50,
  input  logic                    resetn,
  input  logic [1:0]              rate_sel,
  input  logic                    enable,
  input  logic                    up_down,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   load_value,
  output logic [4*N_DIGITS-1:0]   count,
  output logic                    tick,
  output logic                    wrap,
  output logic [7*N_DIGITS-1:0]   hex
);

  localparam int CNT_W = 4 * N_DIGITS;
  localparam int PRE_W = $clog2(4 * PERIOD_CYCLES);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MODULUS - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PRE_W-1:0] term;
  rate_e            rate_q;
  logic             rate_change;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;

  assign term        = PRE_W'(rate_terminal(rate_q, PERIOD_CYCLES));
  assign rate_change = (rate_e'(rate_sel) != rate_q);

  // A rate change restarts the period from zero and suppresses the tick.
  always_comb begin
    tick_d = 1'b0;
    pre_d  = pre_q + PRE_W'(1);
    if (rate_change) begin
      pre_d = '0;
    end else if (pre_q == term) begin
      tick_d = 1'b1;
      pre_d  = '0;
    end
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = (load_value > MAX_CNT) ? MAX_CNT : load_value;
    end else if (tick_q && enable) begin
      if (up_down) begin
        if (count_q == MAX_CNT) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end else begin
        if (count_q == '0) begin
          count_d = MAX_CNT;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      pre_q   <= '0;
      rate_q  <= RATE_FAST;
      tick_q  <= 1'b0;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      rate_q  <= rate_e'(rate_sel);
      tick_q  <= tick_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign wrap  = wrap_q;

  for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
    hex_to_seg7 u_seg (
      .nibble (count_q[4*k +: 4]),
      .seg    (hex[7*k +: 7])
    );
  end

endmodule

// File: tb/tb_multirate_hex_counter.sv
// Bench for multirate_hex_counter: three instances (16-bit full range,
// one-digit modulus 10, 16-bit modulus 1000) share stimulus and a model.
module tb_multirate_hex_counter;
  import multirate_pkg::*;

  localparam int P = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  rate_sel;
  logic        enable, up_down, load;
  logic [15:0] load_value;

  logic [15:0] count_a, count_c;
  logic [3:0]  count_b;
  logic        tick_a, tick_b, tick_c;
  logic        wrap_a, wrap_b, wrap_c;
  logic [27:0] hex_a, hex_c;
  logic [6:0]  hex_b;

  int n_cmp = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  multirate_hex_counter #(.N_DIGITS(4), .PERIOD_CYCLES(P)) dut_a (
    .CLOCK_50(clk), .resetn(resetn), .rate_sel(rate_sel), .enable(enable),
    .up_down(up_down), .load(load), .load_value(load_value),
    .count(count_a), .tick(tick_a), .wrap(wrap_a), .hex(hex_a));

  multirate_hex_counter #(.N_DIGITS(1), .PERIOD_CYCLES(P), .MODULUS(10)) dut_b (
    .CLOCK_50(clk), .resetn(resetn), .rate_sel(rate_sel), .enable(enable),
    .up_down(up_down), .load(load), .load_value(load_value[3:0]),
    .count(count_b), .tick(tick_b), .wrap(wrap_b), .hex(hex_b));

  multirate_hex_counter #(.N_DIGITS(4), .PERIOD_CYCLES(P), .MODULUS(1000)) dut_c (
    .CLOCK_50(clk), .resetn(resetn), .rate_sel(rate_sel), .enable(enable),
    .up_down(up_down), .load(load), .load_value(load_value),
    .count(count_c), .tick(tick_c), .wrap(wrap_c), .hex(hex_c));

  function automatic int mod_of(input int i);
    case (i)
      0:       mod_of = 65536;
      1:       mod_of = 10;
      default: mod_of = 1000;
    endcase
  endfunction

  function automatic int period_of(input int r);
    period_of = (r == 0) ? 1 : (P << (r - 1));
  endfunction

  function automatic int clamped_load(input int i, input logic [15:0] lv);
    int v;
    v = (i == 1) ? int'(lv[3:0]) : int'(lv);
    clamped_load = (v > mod_of(i) - 1) ? mod_of(i) - 1 : v;
  endfunction

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: seg_of = 7'b1000000;  1: seg_of = 7'b1111001;
      2: seg_of = 7'b0100100;  3: seg_of = 7'b0110000;
      4: seg_of = 7'b0011001;  5: seg_of = 7'b0010010;
      6: seg_of = 7'b0000010;  7: seg_of = 7'b1111000;
      8: seg_of = 7'b0000000;  9: seg_of = 7'b0010000;
      10: seg_of = 7'b0001000; 11: seg_of = 7'b0000011;
      12: seg_of = 7'b1000110; 13: seg_of = 7'b0100001;
      14: seg_of = 7'b0000110; default: seg_of = 7'b0001110;
    endcase
  endfunction

  function automatic logic [27:0] hex4_of(input int v);
    logic [27:0] r;
    for (int d = 0; d < 4; d++) r[7*d +: 7] = seg_of((v >> (4 * d)) & 15);
    hex4_of = r;
  endfunction

  // Model: tick marks the end of each period counted from the last restart;
  // the count reacts one edge later according to load/enable/direction.
  int m_cnt [3];
  bit m_wrap [3];
  int m_rate;
  int m_phase;
  bit m_tick;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 3; i++) begin
        m_cnt[i]  <= 0;
        m_wrap[i] <= 1'b0;
      end
      m_rate  <= 0;
      m_phase <= 0;
      m_tick  <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (load) begin
          m_cnt[i]  <= clamped_load(i, load_value);
          m_wrap[i] <= 1'b0;
        end else if (m_tick && enable && up_down) begin
          m_cnt[i]  <= (m_cnt[i] == mod_of(i) - 1) ? 0 : m_cnt[i] + 1;
          m_wrap[i] <= (m_cnt[i] == mod_of(i) - 1);
        end else if (m_tick && enable) begin
          m_cnt[i]  <= (m_cnt[i] == 0) ? mod_of(i) - 1 : m_cnt[i] - 1;
          m_wrap[i] <= (m_cnt[i] == 0);
        end else begin
          m_wrap[i] <= 1'b0;
        end
      end
      if (int'(rate_sel) != m_rate) begin
        m_rate  <= int'(rate_sel);
        m_phase <= 0;
        m_tick  <= 1'b0;
      end else begin
        m_phase <= (m_phase + 1) % period_of(m_rate);
        m_tick  <= ((m_phase + 1) % period_of(m_rate)) == 0;
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("a_count", longint'(count_a), longint'(m_cnt[0]));
      chk("b_count", longint'(count_b), longint'(m_cnt[1]));
      chk("c_count", longint'(count_c), longint'(m_cnt[2]));
      chk("a_tick", longint'(tick_a), longint'(m_tick));
      chk("b_tick", longint'(tick_b), longint'(m_tick));
      chk("c_tick", longint'(tick_c), longint'(m_tick));
      chk("a_wrap", longint'(wrap_a), longint'(m_wrap[0]));
      chk("b_wrap", longint'(wrap_b), longint'(m_wrap[1]));
      chk("c_wrap", longint'(wrap_c), longint'(m_wrap[2]));
      chk("a_hex", longint'(hex_a), longint'(hex4_of(m_cnt[0])));
      chk("b_hex", longint'(hex_b), longint'(seg_of(m_cnt[1])));
      chk("c_hex", longint'(hex_c), longint'(hex4_of(m_cnt[2])));
    end
  end

  task automatic wait_tick(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!tick_a && cyc < 200);
    if (!tick_a) begin
      n_cmp++;
      n_fail++;
      $display("FAIL tick_timeout: no tick within %0d cycles", cyc);
    end
  endtask

  task automatic measure_period(input string name, input int exp);
    int c;
    wait_tick(c);
    wait_tick(c);
    chk(name, longint'(c), longint'(exp));
  endtask

  initial begin
    int c, c0, nticks;
    logic [15:0] snap;
    resetn = 1'b0; rate_sel = 2'd0; enable = 1'b1; up_down = 1'b1;
    load = 1'b0; load_value = 16'h0;
    @(negedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    chk("reset_count", longint'(count_a), 0);
    chk("reset_hex", longint'(hex_a), longint'({4{7'b1000000}}));
    resetn = 1'b1;

    // Rate selection
    measure_period("period_rate0", 1);
    snap = count_a;
    @(negedge clk);
    chk("rate0_step", longint'(count_a - snap), 1);
    rate_sel = 2'd1;
    measure_period("period_rate1", 4);
    rate_sel = 2'd2;
    measure_period("period_rate2", 8);
    rate_sel = 2'd3;
    measure_period("period_rate3", 16);

    // Enable hold while the prescaler keeps ticking
    rate_sel = 2'd1;
    wait_tick(c);
    wait_tick(c);
    enable = 1'b0;
    c0 = int'(count_a);
    nticks = 0;
    repeat (12) begin
      @(negedge clk);
      if (tick_a) nticks++;
    end
    chk("hold_count", longint'(count_a), longint'(c0));
    chk("hold_ticks", longint'(nticks), 3);
    enable = 1'b1;

    // Rate change mid-period restarts the period
    wait_tick(c);
    repeat (2) @(negedge clk);
    rate_sel = 2'd3;
    @(negedge clk);
    wait_tick(c);
    chk("restart_period", longint'(c), 16);

    // Wrap up and down on the modulus-10 digit
    rate_sel = 2'd1;
    wait_tick(c);
    wait_tick(c);
    load = 1'b1; load_value = 16'h0009;
    @(negedge clk);
    load = 1'b0;
    wait_tick(c);
    @(negedge clk);
    chk("wrap_up_count", longint'(count_b), 0);
    chk("wrap_up_pulse", longint'(wrap_b), 1);
    up_down = 1'b0;
    @(negedge clk);
    chk("wrap_up_clear", longint'(wrap_b), 0);
    wait_tick(c);
    @(negedge clk);
    chk("wrap_dn_count", longint'(count_b), 9);
    chk("wrap_dn_pulse", longint'(wrap_b), 1);

    // Load coincident with a tick
    up_down = 1'b1;
    wait_tick(c);
    load = 1'b1; load_value = 16'hFFFF;
    @(negedge clk);
    load = 1'b0;
    chk("load_clamp", longint'(count_c), 999);
    chk("load_wrap", longint'(wrap_c), 0);
    chk("load_no_inc", longint'(count_a), longint'(16'hFFFF));

    // Segment decode
    enable = 1'b0;
    load = 1'b1; load_value = 16'hABCD;
    @(negedge clk);
    load = 1'b0;
    chk("decode_abcd", longint'(hex_a),
        longint'({7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001}));
    chk("decode_pkg_A", longint'(hex_a[27:21]), longint'(SEG_TABLE[10]));

    // Asynchronous reset mid-count
    load = 1'b1; load_value = 16'h0037;
    @(negedge clk);
    load = 1'b0;
    chk("pre_reset", longint'(count_a), longint'(16'h0037));
    @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("async_count", longint'(count_a), 0);
    chk("async_tick", longint'(tick_a), 0);
    chk("async_wrap", longint'(wrap_a), 0);
    chk("async_hex", longint'(hex_a), longint'({4{7'b1000000}}));
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    enable = 1'b1;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multirate_hex_counter.md
Name: multirate_hex_counter

Overview:
Parametrised successor to the fixed four-rate toggle counter. A single prescaler generates a tick at one of four selectable rates. A configurable-width up/down counter advances on each tick, with modulus wrap, synchronous load and pause. Each 4-bit nibble of the count is decoded to an active-low 7-segment pattern for the board HEX displays, so the top level only wires switches to rate_sel and the hex bus to HEX0..HEXn.

Parameters:
N_DIGITS, 4, number of hex digits; counter width CNT_W = 4*N_DIGITS
PERIOD_CYCLES, 50000000, clock cycles per tick at rate_sel=1 (1 s at 50 MHz)
MODULUS, 2**(4*N_DIGITS), count range 0..MODULUS-1; legal range 2..2**CNT_W

Ports:
CLOCK_50  input  1  system clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
rate_sel  input  2  0 = tick every cycle, 1 = PERIOD_CYCLES, 2 = 2*PERIOD_CYCLES, 3 = 4*PERIOD_CYCLES
enable  input  1  1 = count on tick; 0 = hold count, prescaler keeps running
up_down  input  1  1 = increment, 0 = decrement
load  input  1  synchronous load of load_value, highest priority after reset
load_value  input  CNT_W  value to load; if >= MODULUS, loads MODULUS-1
count  output  CNT_W  current count, registered
tick  output  1  one-cycle pulse, high in the cycle the prescaler terminal count is reached
wrap  output  1  one-cycle pulse, registered with the count update that wrapped
hex  output  7*N_DIGITS  digit k at bits [7k+6:7k], bit order g..a (bit 0 = seg a), active low

Behaviour:
- Reset (resetn=0, async assert): prescaler=0, count=0, tick=0, wrap=0. hex then shows all digits "0", i.e. 7'b1000000 per digit.
- Deassertion: first tick at rate_sel=0 occurs in the first clock cycle after release.
- Prescaler: width ceil(log2(4*PERIOD_CYCLES)) bits.
  - Terminal value: rate 0 = 0; rate r>0 = PERIOD_CYCLES*2^(r-1) - 1.
  - tick = (prescaler == terminal). Prescaler clears on tick, otherwise increments.
- rate_sel change: rate_sel is registered once. When the registered value differs from the previous one, the prescaler clears to 0 and no tick is issued that cycle, so there are no spurious short or long periods beyond one restart.
- Count update priority, per cycle:
  1. load: count <= min(load_value, MODULUS-1); wrap <= 0.
  2. tick & enable & up_down: count == MODULUS-1 -> count <= 0, wrap <= 1; else count+1.
  3. tick & enable & !up_down: count == 0 -> count <= MODULUS-1, wrap <= 1; else count-1.
  4. Otherwise: hold; wrap <= 0.
- Latency:
  - count changes the clock edge after tick is high.
  - hex is combinational from count; no extra latency.
- load coinciding with a tick: load wins, and the tick is consumed without counting.
- Segment decode: 0-9 standard; A, b, C, d, E, F for 10-15. 8 lights all segments; 0 lights all except g.

Decomposition:
- Shared package multirate_pkg:
  - RATE_FAST/RATE_1X/RATE_2X/RATE_4X constants for rate_sel.
  - Function for the terminal value.
  - 16-entry active-low segment pattern constant table.
- Sub-module hex_to_seg7 (4-bit in, 7-bit active-low out), instantiated N_DIGITS times via generate.
- Prescaler stays inline.

Test Plan:
- Reset: resetn=0 mid-count (count=0x0037) -> count=0, tick=0, wrap=0 immediately, without waiting for a clock edge; hex=4 x 7'b1000000.
- Rate: PERIOD_CYCLES=4, enable=1, up. rate_sel=1 -> tick every 4 cycles. rate_sel=2 -> every 8. rate_sel=3 -> every 16. rate_sel=0 -> every cycle, count +1 per cycle.
- Wrap up: N_DIGITS=1, MODULUS=10, load 9, tick -> count=0 and wrap pulses 1 cycle. Decrement from 0 -> count=9, wrap=1.
- Load priority: load=1 with load_value=0xFFFF, MODULUS=1000, coincident tick -> count=999, no increment, wrap=0.
- Enable/rate change: enable=0 for 3 ticks -> count unchanged, tick still pulses. Switch rate_sel 1->3 mid-period -> next tick exactly 16 cycles after the registered change.
- Decode: load 0xAbCd -> hex digits show A, b, C, d, with patterns checked against the package table.
